// File: rtl/spi_aggregator_if.sv
// Tile pin bundle for spi_aggregator: tile enable, dedicated inputs/outputs
// and the bidirectional pins. The host or wrapper side uses master, the
// aggregator uses slave.
interface spi_aggregator_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
    modport slave  (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/spi_aggregator.sv
// spi_aggregator: SPI mode-0 peripheral. It collects 8-bit samples and keeps
// the sum, count, min, max and last sample. The host reads the statistics
// back over MISO. A selected statistic is also mirrored on uo_out.
// Optional feature: define SPI_AGG_AVG_EN to add an 8-bit exponential moving
// average. The average is read with command 8'h05 and appears on uo_out at
// select 7.
module spi_aggregator #(
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    spi_aggregator_if.slave  bus
);
    typedef enum logic {S_CMD, S_DATA} state_t;

    localparam logic [7:0] CMD_PUSH  = 8'h80;
    localparam logic [7:0] CMD_CLEAR = 8'hC0;

    // Each stage holds {MOSI, CS_n, SCLK}. At reset SCLK is idle low and CS_n is inactive.
    logic [SYNC_STAGES-1:0][2:0] r_sync;
    logic        r_sclk_d;
    state_t      r_state, w_state_nxt;
    logic [2:0]  r_bitcnt;
    logic [7:0]  r_shift;
    logic [7:0]  r_cmd;
    logic [15:0] r_resp;
    logic        r_miso;
    logic        r_smp_vld, r_clr;
    logic [7:0]  r_smp;
    logic [15:0] r_sum, r_count;
    logic [7:0]  r_min, r_max, r_last;
    logic        r_ovf;
    logic        w_sclk, w_csn, w_mosi, w_rise, w_fall, w_byte_done;
    logic [7:0]  w_byte;
    logic [15:0] w_snap;
    logic [16:0] w_sum_ext;
    logic        w_unused;

    assign w_sclk      = r_sync[SYNC_STAGES-1][0];
    assign w_csn       = r_sync[SYNC_STAGES-1][1];
    assign w_mosi      = r_sync[SYNC_STAGES-1][2];
    assign w_rise      = w_sclk & ~r_sclk_d;
    assign w_fall      = ~w_sclk & r_sclk_d;
    assign w_byte      = {r_shift[6:0], w_mosi};
    assign w_byte_done = w_rise & ~w_csn & (r_bitcnt == 3'd7);
    assign w_sum_ext   = {1'b0, r_sum} + {9'd0, r_smp};
    assign w_unused    = &{1'b0, bus.ena, bus.uio_in, bus.ui_in[4:3]};

`ifdef SPI_AGG_AVG_EN
    logic [7:0]        r_avg;
    logic              r_avg_first;
    logic signed [9:0] w_diff, w_step;
    logic [9:0]        w_avg_sum;
    // The shift is kept in its own signed net so that it stays arithmetic.
    assign w_diff    = $signed({2'b00, r_smp}) - $signed({2'b00, r_avg});
    assign w_step    = w_diff >>> 2;
    assign w_avg_sum = {2'b00, r_avg} + w_step;
`endif

    // Input synchronizer and SCLK edge-detect history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync   <= {SYNC_STAGES{3'b010}};
            r_sclk_d <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], bus.ui_in[2:0]};
            r_sclk_d <= w_sclk;
        end
    end

    // Frame state: the first byte is the command; the remaining bytes are data or response
    always_comb begin
        w_state_nxt = r_state;
        if (w_csn)
            w_state_nxt = S_CMD;
        else if (w_byte_done && r_state == S_CMD)
            w_state_nxt = S_DATA;
    end

    // Response snapshot, taken from the live statistics as the command byte completes
    always_comb begin
        w_snap = 16'h0000;
        case (w_byte)
            8'h01: w_snap = r_sum;
            8'h02: w_snap = r_count;
            8'h03: w_snap = {r_min, 8'h00};
            8'h04: w_snap = {r_max, 8'h00};
`ifdef SPI_AGG_AVG_EN
            8'h05: w_snap = {r_avg, 8'h00};
`endif
            8'h06: w_snap = {r_last, 8'h00};
            8'h07: w_snap = {r_ovf, 15'd0};
            default: w_snap = 16'h0000;
        endcase
    end

    // SPI shifter: sample MOSI on rising edges and drive MISO on falling edges.
    // It also issues one-cycle sample and clear requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_CMD;
            r_bitcnt  <= 3'd0;
            r_shift   <= 8'h00;
            r_cmd     <= 8'h00;
            r_resp    <= 16'h0000;
            r_miso    <= 1'b0;
            r_smp_vld <= 1'b0;
            r_smp     <= 8'h00;
            r_clr     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_smp_vld <= 1'b0;
            r_clr     <= 1'b0;
            if (w_csn) begin
                r_bitcnt <= 3'd0;
                r_miso   <= 1'b0;
                r_resp   <= 16'h0000;
            end else begin
                if (w_rise) begin
                    r_shift  <= w_byte;
                    r_bitcnt <= r_bitcnt + 3'd1;
                end
                if (w_byte_done) begin
                    if (r_state == S_CMD) begin
                        r_cmd  <= w_byte;
                        r_resp <= w_snap;
                        r_clr  <= (w_byte == CMD_CLEAR);
                    end else if (r_cmd == CMD_PUSH) begin
                        r_smp_vld <= 1'b1;
                        r_smp     <= w_byte;
                    end
                end
                if (w_fall && r_state == S_DATA) begin
                    r_miso <= r_resp[15];
                    r_resp <= {r_resp[14:0], 1'b0};
                end
            end
        end
    end

    // Statistics: restore reset values on CLEAR; fold one sample in on each push
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum   <= 16'h0000;
            r_count <= 16'h0000;
            r_min   <= 8'hFF;
            r_max   <= 8'h00;
            r_last  <= 8'h00;
            r_ovf   <= 1'b0;
        end else if (r_clr) begin
            r_sum   <= 16'h0000;
            r_count <= 16'h0000;
            r_min   <= 8'hFF;
            r_max   <= 8'h00;
            r_last  <= 8'h00;
            r_ovf   <= 1'b0;
        end else if (r_smp_vld) begin
            r_sum   <= w_sum_ext[16] ? 16'hFFFF : w_sum_ext[15:0];
            r_ovf   <= r_ovf | w_sum_ext[16];
            r_count <= (r_count == 16'hFFFF) ? r_count : r_count + 16'd1;
            r_min   <= (r_smp < r_min) ? r_smp : r_min;
            r_max   <= (r_smp > r_max) ? r_smp : r_max;
            r_last  <= r_smp;
        end
    end

`ifdef SPI_AGG_AVG_EN
    // Moving average; the first sample after reset or CLEAR seeds it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_avg       <= 8'h00;
            r_avg_first <= 1'b1;
        end else if (r_clr) begin
            r_avg       <= 8'h00;
            r_avg_first <= 1'b1;
        end else if (r_smp_vld) begin
            r_avg       <= r_avg_first ? r_smp : w_avg_sum[7:0];
            r_avg_first <= 1'b0;
        end
    end
`endif

    // Debug mirror of the selected statistic
    always_comb begin
        bus.uo_out = 8'h00;
        case (bus.ui_in[7:5])
            3'd0: bus.uo_out = r_sum[7:0];
            3'd1: bus.uo_out = r_sum[15:8];
            3'd2: bus.uo_out = r_count[7:0];
            3'd3: bus.uo_out = r_min;
            3'd4: bus.uo_out = r_max;
            3'd5: bus.uo_out = r_last;
            3'd6: bus.uo_out = {r_ovf, ~w_csn, 6'b0};
`ifdef SPI_AGG_AVG_EN
            3'd7: bus.uo_out = r_avg;
`endif
            default: bus.uo_out = 8'h00;
        endcase
    end

    assign bus.uio_out = {7'b0, r_miso};
    assign bus.uio_oe  = 8'h01;
endmodule

// File: tb/tb_spi_aggregator.sv
// Directed self-checking bench for spi_aggregator. The host runs SCLK at clk/8.
module tb_spi_aggregator;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sclk = 1'b0, csn = 1'b1, mosi = 1'b0;
    logic [2:0] sel = 3'd0;
    int checks = 0;
    int errors = 0;

    spi_aggregator_if bus();
    assign bus.ena    = 1'b1;
    assign bus.uio_in = 8'h00;
    assign bus.ui_in  = {sel, 2'b00, mosi, csn, sclk};

    spi_aggregator #(.SYNC_STAGES(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    typedef struct { logic [2:0] sel; logic [7:0] exp; } sel_vec_t;
    typedef struct { logic [7:0] cmd; logic [23:0] exp; } rd_vec_t;

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            mosi = tx[i];
            wait_clk(4);
            rx[i] = bus.uio_out[0];
            sclk = 1'b1;
            wait_clk(4);
            sclk = 1'b0;
        end
    endtask

    task automatic frame_begin();
        csn = 1'b0;
        wait_clk(4);
    endtask

    task automatic frame_end();
        wait_clk(4);
        csn = 1'b1;
        wait_clk(8);
    endtask

    // Command followed by three response bytes; the third is beyond every response.
    task automatic spi_read(input logic [7:0] cmd, output logic [23:0] r);
        logic [7:0] d;
        frame_begin();
        xfer(cmd, d);
        xfer(8'h00, r[23:16]);
        xfer(8'h00, r[15:8]);
        xfer(8'h00, r[7:0]);
        frame_end();
    endtask

    task automatic push2(input logic [7:0] cmd, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] d;
        frame_begin();
        xfer(cmd, d);
        xfer(a, d);
        xfer(b, d);
        frame_end();
    endtask

    initial begin
        sel_vec_t rst_tab[6];
        sel_vec_t stat_tab[6];
        rd_vec_t  rd_tab[8];
        rd_vec_t  clr_tab[5];
        logic [23:0] r;
        logic [7:0]  d;
        logic [7:0]  avg_a, avg_b;
`ifdef SPI_AGG_AVG_EN
        avg_a = 8'h37;  // 10 -> 48 -> 37
        avg_b = 8'h50;  // 40 -> 50
`else
        avg_a = 8'h00;
        avg_b = 8'h00;
`endif
        rst_tab  = '{'{3'd0, 8'h00}, '{3'd1, 8'h00}, '{3'd2, 8'h00},
                     '{3'd3, 8'hFF}, '{3'd4, 8'h00}, '{3'd5, 8'h00}};
        stat_tab = '{'{3'd0, 8'h05}, '{3'd1, 8'h01}, '{3'd2, 8'h03},
                     '{3'd3, 8'h05}, '{3'd4, 8'hF0}, '{3'd5, 8'h05}};
        rd_tab   = '{'{8'h01, 24'h010500}, '{8'h02, 24'h000300}, '{8'h03, 24'h050000},
                     '{8'h04, 24'hF00000}, '{8'h06, 24'h050000}, '{8'h07, 24'h000000},
                     '{8'h05, {avg_a, 16'h0000}}, '{8'h3A, 24'h000000}};
        clr_tab  = '{'{8'h01, 24'h000000}, '{8'h02, 24'h000000}, '{8'h03, 24'hFF0000},
                     '{8'h04, 24'h000000}, '{8'h07, 24'h000000}};

        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(4);

        // Reset state
        for (int i = 0; i < 6; i++) begin
            sel = rst_tab[i].sel;
            wait_clk(1);
            chk($sformatf("rst_sel%0d", rst_tab[i].sel), {16'h0, bus.uo_out}, {16'h0, rst_tab[i].exp});
        end
        chk("uio_oe", {16'h0, bus.uio_oe}, 24'h000001);
        chk("uio_out", {16'h0, bus.uio_out}, 24'h000000);

        // Push 10, F0, 05
        frame_begin();
        xfer(8'h80, d); xfer(8'h10, d); xfer(8'hF0, d); xfer(8'h05, d);
        frame_end();
        for (int i = 0; i < 6; i++) begin
            sel = stat_tab[i].sel;
            wait_clk(1);
            chk($sformatf("stat_sel%0d", stat_tab[i].sel), {16'h0, bus.uo_out}, {16'h0, stat_tab[i].exp});
        end
        for (int i = 0; i < 8; i++) begin
            spi_read(rd_tab[i].cmd, r);
            chk($sformatf("read_%h", rd_tab[i].cmd), r, rd_tab[i].exp);
        end

        // Saturation: 258 samples of FF in a single frame
        frame_begin();
        xfer(8'h80, d);
        for (int i = 0; i < 258; i++) xfer(8'hFF, d);
        frame_end();
        spi_read(8'h01, r); chk("sat_sum", r, 24'hFFFF00);
        spi_read(8'h02, r); chk("sat_count", r, 24'h010500);
        spi_read(8'h07, r); chk("sat_status", r, 24'h800000);
        sel = 3'd6; wait_clk(1);
        chk("sel6_ovf", {16'h0, bus.uo_out}, 24'h000080);
        csn = 1'b0; wait_clk(4);
        chk("sel6_cs_active", {16'h0, bus.uo_out}, 24'h0000C0);
        csn = 1'b1; wait_clk(4);

        // A partial byte is discarded when CS_n rises after 5 bits
        frame_begin();
        xfer(8'h80, d);
        for (int i = 0; i < 5; i++) begin
            mosi = 1'b1; wait_clk(4); sclk = 1'b1; wait_clk(4); sclk = 1'b0;
        end
        frame_end();
        spi_read(8'h02, r); chk("partial_count", r, 24'h010500);

        // CLEAR; the trailing byte in the same frame must be ignored
        push2(8'hC0, 8'h55, 8'h66);
        for (int i = 0; i < 5; i++) begin
            spi_read(clr_tab[i].cmd, r);
            chk($sformatf("clr_read_%h", clr_tab[i].cmd), r, clr_tab[i].exp);
        end

        // Moving average seeded by the first sample after CLEAR
        push2(8'h80, 8'h40, 8'h80);
        spi_read(8'h05, r); chk("avg_40_80", r, {avg_b, 16'h0000});
        sel = 3'd7; wait_clk(1);
        chk("sel7", {16'h0, bus.uo_out}, {16'h0, avg_b});
        spi_read(8'h01, r); chk("sum_40_80", r, 24'h00C000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
